// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin output arbiter.
// Build option: MUX_ARB_LOCK_EN adds packet locking (req_last input, OPEN/LOCKED state).
package mux_arb_pkg;

  // Select width for an n-way choice; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

`ifdef MUX_ARB_LOCK_EN
  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;
`endif

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
// Works for any N, not just powers of two; ptr is assumed to be below N.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] idx,
  output logic [N-1:0]  onehot
);

  int k;

  // Scan N positions starting at ptr; the first hit wins and later hits are ignored.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = SW'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 arbiter with a registered valid/ready output slice.
// Build option: MUX_ARB_LOCK_EN keeps the grant on one requester until its req_last beat.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]    req_last,
`endif
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic [SW-1:0] ptr;
  logic          vld_p1;
  logic [W-1:0]  data_p1;
  logic [SW-1:0] sel_p1;

  logic          load;
  logic [N-1:0]  req_eff;
  logic          any;
  logic [SW-1:0] idx;
  logic [N-1:0]  onehot;
  logic          grant;
  logic          adv;
  logic [SW-1:0] ptr_nxt;

  assign load  = !vld_p1 || out_ready;
  assign grant = load && any && !rst;

`ifdef MUX_ARB_LOCK_EN
  arb_state_t    state_q, state_d;
  logic [SW-1:0] lock_q, lock_d;

  // While locked, only the owning requester is visible to the picker.
  always_comb begin
    req_eff = '0;
    for (int i = 0; i < N; i++) begin
      req_eff[i] = req_valid[i] && ((state_q == OPEN) || (lock_q == SW'(i)));
    end
  end

  // Lock on a non-final beat, reopen on the final beat of the packet.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (grant) begin
      if (req_last[idx]) begin
        state_d = OPEN;
      end else begin
        state_d = LOCKED;
        lock_d  = idx;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OPEN;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // The rotation pointer only moves once a packet completes.
  assign adv = req_last[idx];
`else
  assign req_eff = req_valid;
  assign adv     = 1'b1;
`endif

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req    (req_eff),
    .ptr    (ptr),
    .any    (any),
    .idx    (idx),
    .onehot (onehot)
  );

  assign ptr_nxt   = (idx == SW'(N - 1)) ? '0 : idx + SW'(1);
  assign req_ready = grant ? onehot : '0;

  // ---- stage p1: output register, loads only when empty or being drained ----
  // Capture the winning beat; an empty load cycle drops valid but keeps data/sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any) begin
        vld_p1  <= 1'b1;
        data_p1 <= req_data[int'(idx)*W +: W];
        sel_p1  <= idx;
        if (adv) ptr <= ptr_nxt;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule
